// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter and the CPU variants built on it.
package mem_arb_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int STARVE_W = 8;

  localparam logic PORT_IM = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory-side bus of the arbiter, grouped in one interface.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // Handshake: a requester holds req and its payload until the cycle where gnt=1;
  // the access is taken at that edge, and a read answers with rvalid exactly one
  // cycle later. req still high after gnt counts as a fresh request.
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_gnt;
  logic          im_rvalid;
  logic [DW-1:0] im_rdata;

  logic          dm_req;
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  im_req, im_addr, dm_req, dm_addr, dm_we, dm_wdata, mem_dout,
    output im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_we, mem_din
  );

  modport master (
    output im_req, im_addr, dm_req, dm_addr, dm_we, dm_wdata, mem_dout,
    input  im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port has been denied.
module starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] count
);
  localparam logic [STARVE_W-1:0] MAX = STARVE_W'(STARVE_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Data-first arbiter sharing one memory between fetch and load/store, with a
// fetch starvation guard and one-cycle read responses routed to the issuing port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_arbiter_if.slave        bus,
  output logic [STARVE_W-1:0] starve
);
  logic starve_hit;
  logic im_gnt;
  logic dm_gnt;
  logic rd_pend;
  logic rd_port;

  assign starve_hit = (starve == STARVE_W'(STARVE_MAX));

  // Fetch only overtakes a pending data request once it has waited STARVE_MAX cycles.
  always_comb begin
    im_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!reset) begin
      if (bus.im_req && bus.dm_req) begin
        im_gnt = starve_hit;
        dm_gnt = !starve_hit;
      end else begin
        im_gnt = bus.im_req;
        dm_gnt = bus.dm_req;
      end
    end
  end

  assign bus.im_gnt   = im_gnt;
  assign bus.dm_gnt   = dm_gnt;
  assign bus.mem_addr = dm_gnt ? bus.dm_addr : bus.im_addr;
  assign bus.mem_we   = dm_gnt & bus.dm_we;
  assign bus.mem_din  = bus.dm_wdata;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.im_req & ~im_gnt),
    .clr   (im_gnt | ~bus.im_req),
    .count (starve)
  );

  // Stores retire at the grant edge, so only reads leave a response pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_port <= PORT_IM;
    end else begin
      rd_pend <= im_gnt | (dm_gnt & ~bus.dm_we);
      rd_port <= (dm_gnt & ~bus.dm_we) ? PORT_DM : PORT_IM;
    end
  end

  assign bus.im_rvalid = rd_pend & (rd_port == PORT_IM);
  assign bus.dm_rvalid = rd_pend & (rd_port == PORT_DM);
  assign bus.im_rdata  = bus.mem_dout;
  assign bus.dm_rdata  = bus.mem_dout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with STARVE_MAX=3 and a small word memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic                clk;
  logic                reset;
  logic [STARVE_W-1:0] starve;
  logic [31:0]         mem [0:4095];
  logic [31:0]         exp_q[$];
  int                  total;
  int                  bad;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.STARVE_MAX(3), .AW(32), .DW(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .starve (starve)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: write at grant edge, read data one cycle later
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[13:2]] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr[13:2]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic im_r, input logic [31:0] im_a,
                       input logic dm_r, input logic [31:0] dm_a,
                       input logic we, input logic [31:0] wd);
    bus.im_req   = im_r;
    bus.im_addr  = im_a;
    bus.dm_req   = dm_r;
    bus.dm_addr  = dm_a;
    bus.dm_we    = we;
    bus.dm_wdata = wd;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_resp(input string tag, input logic port);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (port == PORT_IM) begin
      check({tag, "_im_rvalid"}, {31'd0, bus.im_rvalid}, 32'd1);
      check({tag, "_dm_rvalid"}, {31'd0, bus.dm_rvalid}, 32'd0);
      check({tag, "_im_rdata"}, bus.im_rdata, e);
    end else begin
      check({tag, "_dm_rvalid"}, {31'd0, bus.dm_rvalid}, 32'd1);
      check({tag, "_im_rvalid"}, {31'd0, bus.im_rvalid}, 32'd0);
      check({tag, "_dm_rdata"}, bus.dm_rdata, e);
    end
  endtask

  initial begin
    logic [7:0] im_pat;
    total = 0;
    bad = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0] = 32'h2008_000A;
    mem[1] = 32'h1234_5678;
    bus.mem_dout = '0;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);

    // 1: reset held with both requesting
    next_cycle();
    drive(1'b1, RESET_PC, 1'b1, 32'h2000, 1'b0, '0);
    next_cycle();
    sample();
    check("rst_im_gnt", {31'd0, bus.im_gnt}, 32'd0);
    check("rst_dm_gnt", {31'd0, bus.dm_gnt}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_starve", {24'd0, starve}, 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    sample();
    check("post_rst_im_rvalid", {31'd0, bus.im_rvalid}, 32'd0);
    check("post_rst_dm_rvalid", {31'd0, bus.dm_rvalid}, 32'd0);

    // 2: lone fetch
    next_cycle();
    drive(1'b1, RESET_PC, 1'b0, '0, 1'b0, '0);
    sample();
    check("f_im_gnt", {31'd0, bus.im_gnt}, 32'd1);
    check("f_dm_gnt", {31'd0, bus.dm_gnt}, 32'd0);
    check("f_mem_addr", bus.mem_addr, 32'h0040_0000);
    exp_q.push_back(32'h2008_000A);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    sample();
    check_resp("f", PORT_IM);

    // 3: store wins over concurrent fetch, fetch follows, load returns stored word
    next_cycle();
    drive(1'b1, 32'h0040_0004, 1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF);
    sample();
    check("st_dm_gnt", {31'd0, bus.dm_gnt}, 32'd1);
    check("st_im_gnt", {31'd0, bus.im_gnt}, 32'd0);
    check("st_mem_we", {31'd0, bus.mem_we}, 32'd1);
    check("st_mem_addr", bus.mem_addr, 32'h2000);
    check("st_mem_din", bus.mem_din, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b1, 32'h0040_0004, 1'b0, '0, 1'b0, '0);
    sample();
    check("st_next_im_gnt", {31'd0, bus.im_gnt}, 32'd1);
    check("st_next_im_rvalid", {31'd0, bus.im_rvalid}, 32'd0);
    check("st_next_dm_rvalid", {31'd0, bus.dm_rvalid}, 32'd0);
    exp_q.push_back(32'h1234_5678);
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h2000, 1'b0, '0);
    sample();
    check("ld_dm_gnt", {31'd0, bus.dm_gnt}, 32'd1);
    check("ld_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check_resp("f2", PORT_IM);
    exp_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    sample();
    check_resp("ld", PORT_DM);

    // 4: both requesting continuously, STARVE_MAX=3
    im_pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive(1'b1, RESET_PC, 1'b1, 32'h2000, 1'b0, '0);
      sample();
      check($sformatf("starve_im_gnt_%0d", i), {31'd0, bus.im_gnt}, {31'd0, im_pat[i]});
      check($sformatf("starve_dm_gnt_%0d", i), {31'd0, bus.dm_gnt}, {31'd0, ~im_pat[i]});
    end
    exp_q.push_back(32'h2008_000A);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    sample();
    check_resp("starve_last", PORT_IM);

    // 5: data load then fetch back to back
    next_cycle();
    drive(1'b0, '0, 1'b1, 32'h2000, 1'b0, '0);
    sample();
    check("alt_dm_gnt", {31'd0, bus.dm_gnt}, 32'd1);
    exp_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    drive(1'b1, RESET_PC, 1'b0, '0, 1'b0, '0);
    sample();
    check("alt_im_gnt", {31'd0, bus.im_gnt}, 32'd1);
    check_resp("alt_ld", PORT_DM);
    exp_q.push_back(32'h2008_000A);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    sample();
    check_resp("alt_f", PORT_IM);

    // 6a: reset in the cycle of a fetch request suppresses grant and response
    next_cycle();
    reset = 1'b1;
    drive(1'b1, RESET_PC, 1'b0, '0, 1'b0, '0);
    sample();
    check("rg_im_gnt", {31'd0, bus.im_gnt}, 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    sample();
    check("rg_im_rvalid", {31'd0, bus.im_rvalid}, 32'd0);
    check("rg_dm_rvalid", {31'd0, bus.dm_rvalid}, 32'd0);
    check("rg_starve", {24'd0, starve}, 32'd0);

    // 6b: reset right after a fetch grant still returns that fetch
    next_cycle();
    drive(1'b1, RESET_PC, 1'b0, '0, 1'b0, '0);
    sample();
    check("ra_im_gnt", {31'd0, bus.im_gnt}, 32'd1);
    exp_q.push_back(32'h2008_000A);
    next_cycle();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    sample();
    check_resp("ra", PORT_IM);
    next_cycle();
    reset = 1'b0;
    sample();
    check("ra_after_im_rvalid", {31'd0, bus.im_rvalid}, 32'd0);
    check("ra_q_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the CPU's instruction-fetch port and its load/store data port. It is the prerequisite for the multicycle/pipelined CPU variants, where fetch and data access compete for the same memory each cycle. Arbitration is data-first with a starvation guard for fetch. Read responses are routed back to the issuing port with fixed one-cycle latency.

## Interface
Parameters:
- `STARVE_MAX`, default 4: maximum number of consecutive cycles fetch may be denied while requesting. Legal range 1..255.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `im_req` in 1: fetch request. Held with `im_addr` until granted.
- `im_addr` in AW: fetch byte address.
- `im_gnt` out 1: fetch granted this cycle.
- `im_rvalid` out 1: `im_rdata` valid this cycle.
- `im_rdata` out DW: fetched instruction.
- `dm_req` in 1: data request. Held with `dm_addr`, `dm_we`, `dm_wdata` until granted.
- `dm_addr` in AW: data byte address.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_wdata` in DW: store data.
- `dm_gnt` out 1: data granted this cycle.
- `dm_rvalid` out 1: `dm_rdata` valid this cycle (loads only).
- `dm_rdata` out DW: load data.
- `mem_addr` out AW: address to memory.
- `mem_we` out 1: memory write enable.
- `mem_din` out DW: memory write data.
- `mem_dout` in DW: memory read data, valid one cycle after the address is presented.

## Operation
- Grant logic is combinational from `im_req`, `dm_req`, `reset`, and the registered starvation counter `starve`.
- If `reset` = 1, there are no grants.
- If only one port requests, that port is granted.
- If both ports request, `dm` is granted unless `starve == STARVE_MAX`, in which case `im` is granted.
- `im_gnt` and `dm_gnt` are never both 1.
- Memory drive:
  - The granted port's address is muxed onto `mem_addr`.
  - `mem_we` = `dm_gnt & dm_we`.
  - `mem_din` = `dm_wdata`.
  - With no grant: `mem_we` = 0, and `mem_addr` holds the `im_addr` mux default.
- Starvation counter `starve`:
  - Cleared on reset.
  - Increments (saturating at `STARVE_MAX`) when `im_req & !im_gnt`.
  - Cleared when `im_gnt` or `!im_req`.
- Response tracking uses a registered `rd_pend` (1 bit) and `rd_port` (1 bit, 0 = im, 1 = dm).
  - Set on any granted read: an `im` grant, or a `dm` grant with `dm_we` = 0.
  - Cleared otherwise.
- Response outputs:
  - `im_rvalid` = `rd_pend & !rd_port`.
  - `dm_rvalid` = `rd_pend & rd_port`.
  - `im_rdata` and `dm_rdata` are both driven from `mem_dout` and are only meaningful while the matching `rvalid` is high.
- Stores produce no `rvalid`. The store is complete at the `dm_gnt` edge.

## Timing
- Grant cycle N: `gnt` = 1 and memory inputs are driven in N. The write takes effect at the end of N.
- Read latency: data and `rvalid` arrive in cycle N+1 for exactly one cycle.
- Throughput: one access per cycle. A new grant may occur in N+1 while the N response is being returned.
- Requesters may drop `req` in the cycle after `gnt`. Holding `req` after `gnt` is treated as a new request.
- Reset values: `starve` = 0, `rd_pend` = 0, `rd_port` = 0, both `rvalid` = 0, both `gnt` = 0, `mem_we` = 0.
- Reset asserted in N+1 after a read grant in N: `rvalid` in N+1 is still driven from `rd_pend`. The read issued in N completes normally.
- Reset asserted in N: no grant in N, so no `rvalid` in N+1.
- Starvation bound: with both ports continuously requesting, fetch is granted at least once every `STARVE_MAX`+1 cycles.

## Structure
- Shared package `mem_arb_pkg`:
  - `PORT_IM` = 1'b0 and `PORT_DM` = 1'b1.
  - Default `AW`/`DW` constants.
  - Reset PC constant 32'h00400000, reused by the CPU.
- One sub-module, `starve_ctr`: the saturating counter, parameterised by `STARVE_MAX`, with inputs `inc` and `clr`.
- Grant mux and response tracking stay in `mem_arbiter`.

## Test plan
1. Reset held with both `req` = 1 → both `gnt` = 0, `mem_we` = 0. In the cycle after reset, `im_rvalid` = `dm_rvalid` = 0.
2. `im_req` alone at 0x00400000, memory word 0x2008000A → `im_gnt` in N, `mem_addr` = 0x00400000; `im_rvalid` = 1 and `im_rdata` = 0x2008000A in N+1; `dm_rvalid` = 0.
3. `dm` store to 0x2000 of 0xDEADBEEF concurrent with `im_req` → `dm_gnt` and `mem_we` in N; `im_gnt` in N+1; no `rvalid` in N+1. A later `dm` load of 0x2000 returns 0xDEADBEEF.
4. `STARVE_MAX` = 3, both `req` held 8 cycles → grant sequence dm, dm, dm, im, dm, dm, dm, im.
5. Alternating `dm` load at 0x2000 (N) and `im` fetch (N+1) → `dm_rvalid` in N+1 and `im_rvalid` in N+2, each with the correct word and no cross-port `rvalid`.
6. Reset asserted in the cycle of an `im` grant → no `im_rvalid` in the next cycle; `starve` reads 0 after reset.
